// File: rtl/cache_fill_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : cache_fill_arbiter_if
// Brief   : Cache-miss / memory / fill-port bundle for the shared miss handler.
// Revision: 1.0
// ============================================================================
interface cache_fill_arbiter_if;
  logic        miss_I;
  logic [15:0] addr_I;
  logic        miss_D;
  logic [15:0] addr_D;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_valid;
  logic [15:0] fsm_addr;
  logic [15:0] fsm_data;
  logic        data_we_I;
  logic        data_we_D;
  logic        meta_we_I;
  logic        meta_we_D;
  logic        stall_I;
  logic        stall_D;

  modport master (
    input  miss_I, addr_I, miss_D, addr_D, mem_data, mem_valid,
    output mem_en, mem_addr, fsm_addr, fsm_data,
           data_we_I, data_we_D, meta_we_I, meta_we_D, stall_I, stall_D
  );

  modport slave (
    output miss_I, addr_I, miss_D, addr_D, mem_data, mem_valid,
    input  mem_en, mem_addr, fsm_addr, fsm_data,
           data_we_I, data_we_D, meta_we_I, meta_we_D, stall_I, stall_D
  );
endinterface
`default_nettype wire

// File: rtl/cache_fill_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : cache_fill_arbiter
// Brief   : Round-robin I/D miss arbiter fetching one 8-word block per miss.
// Revision: 1.0
// ============================================================================
module cache_fill_arbiter #(
  parameter int MEM_LAT = 4,
  parameter int WORDS   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  cache_fill_arbiter_if.master bus
);
  localparam int c_OFF_W = $clog2(WORDS);
  localparam int c_INF_W = $clog2(MEM_LAT + 1);
  localparam logic c_SIDE_I = 1'b0;
  localparam logic c_SIDE_D = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_META = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_gnt;
  logic                 r_last;
  logic [11:0]          r_base;
  logic [c_OFF_W:0]     r_issue_cnt;
  logic [c_OFF_W-1:0]   r_ret_cnt;
  logic [c_INF_W-1:0]   r_inflight;
  logic                 w_any_miss;
  logic                 w_grant;
  logic                 w_gnt_nxt;
  logic                 w_mem_en;
  logic                 w_ret;
  logic                 w_busy;
  logic                 w_unused_addr_lsbs;

  assign w_unused_addr_lsbs = ^{bus.addr_I[3:0], bus.addr_D[3:0]};

  assign w_any_miss = bus.miss_I | bus.miss_D;
  assign w_grant    = (r_state == S_IDLE) && w_any_miss;
  // On a tie the side that was not served last wins.
  assign w_gnt_nxt  = (bus.miss_I && bus.miss_D) ? ~r_last : bus.miss_D;
  assign w_busy     = (r_state != S_IDLE);
  assign w_mem_en   = (r_state == S_FILL) && (r_issue_cnt < (c_OFF_W+1)'(WORDS));
  // A return is only accepted while a read is actually outstanding.
  assign w_ret      = (r_state == S_FILL) && bus.mem_valid && (r_inflight != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt       <= c_SIDE_I;
      r_last      <= c_SIDE_I;
      r_base      <= '0;
      r_issue_cnt <= '0;
      r_ret_cnt   <= '0;
      r_inflight  <= '0;
    end else if (w_grant) begin
      r_gnt       <= w_gnt_nxt;
      r_last      <= w_gnt_nxt;
      r_base      <= (w_gnt_nxt == c_SIDE_D) ? bus.addr_D[15:4] : bus.addr_I[15:4];
      r_issue_cnt <= '0;
      r_ret_cnt   <= '0;
      r_inflight  <= '0;
    end else begin
      if (w_mem_en) r_issue_cnt <= r_issue_cnt + 1'b1;
      if (w_ret)    r_ret_cnt   <= r_ret_cnt + 1'b1;
      r_inflight <= r_inflight + c_INF_W'(w_mem_en) - c_INF_W'(w_ret);
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    bus.mem_en    = 1'b0;
    bus.mem_addr  = '0;
    bus.fsm_addr  = '0;
    bus.fsm_data  = '0;
    bus.data_we_I = 1'b0;
    bus.data_we_D = 1'b0;
    bus.meta_we_I = 1'b0;
    bus.meta_we_D = 1'b0;
    bus.stall_I   = bus.miss_I | (w_busy && r_gnt == c_SIDE_I);
    bus.stall_D   = bus.miss_D | (w_busy && r_gnt == c_SIDE_D);

    case (r_state)
      S_IDLE: if (w_any_miss) w_state_nxt = S_FILL;
      S_FILL: if (w_ret && r_ret_cnt == c_OFF_W'(WORDS - 1)) w_state_nxt = S_META;
      S_META: w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase

    // Strobes drop while reset is held so an aborted fill writes nothing.
    if (!rst) begin
      if (w_mem_en) begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = {r_base, r_issue_cnt[c_OFF_W-1:0], 1'b0};
      end
      if (w_ret) begin
        bus.data_we_I = (r_gnt == c_SIDE_I);
        bus.data_we_D = (r_gnt == c_SIDE_D);
        bus.fsm_data  = bus.mem_data;
        bus.fsm_addr  = {r_base, r_ret_cnt, 1'b0};
      end else if (r_state == S_META) begin
        bus.meta_we_I = (r_gnt == c_SIDE_I);
        bus.meta_we_D = (r_gnt == c_SIDE_D);
        bus.fsm_addr  = {r_base, 4'h0};
      end
    end
  end
endmodule
`default_nettype wire
